// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller and graphics pipeline:
// game state encoding, overlay message codes, BCD digit type and screen limits.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  localparam logic [1:0] MSG_NONE  = 2'd0;
  localparam logic [1:0] MSG_START = 2'd1;
  localparam logic [1:0] MSG_READY = 2'd2;
  localparam logic [1:0] MSG_OVER  = 2'd3;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MAX_X = 640;
  localparam int unsigned MAX_Y = 480;

  // Two-digit BCD magnitude compare; valid BCD orders like plain binary
  // once the tens digit is placed above the units digit.
  function automatic logic bcd_gt(input bcd_digit_t a1, input bcd_digit_t a0,
                                  input bcd_digit_t b1, input bcd_digit_t b0);
    return {a1, a0} > {b1, b0};
  endfunction

endpackage

// File: rtl/pong_bcd_counter.sv
// Two-digit BCD up-counter with synchronous clear (clear beats increment).
// Wraps 99 -> 00.
module pong_bcd_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t d1,
  output bcd_digit_t d0
);

  bcd_digit_t d1_q, d0_q;

  // Digit registers: units roll 9 -> 0 and carry into tens, tens roll 9 -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q <= '0;
      d0_q <= '0;
    end else if (clr) begin
      d1_q <= '0;
      d0_q <= '0;
    end else if (inc) begin
      if (d0_q == 4'd9) begin
        d0_q <= '0;
        d1_q <= (d1_q == 4'd9) ? '0 : d1_q + 4'd1;
      end else begin
        d0_q <= d0_q + 4'd1;
      end
    end
  end

  assign d1 = d1_q;
  assign d0 = d0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencing controller: serve / play / ball lost / game over,
// BCD score, remaining balls, inter-ball delay and overlay message select.
// Optional build macro PONG_HISCORE_EN adds a persistent high-score register.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned BALLS       = 3,
  parameter int unsigned DELAY_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic [1:0] msg_sel,
  output logic [3:0] hi_d1,
  output logic [3:0] hi_d0
);

  localparam logic [1:0] BALLS_INIT = 2'(BALLS - 1);
  localparam logic [7:0] DELAY_INIT = 8'(DELAY_TICKS);

  game_state_t state_q, state_d;
  logic [1:0]  balls_q, balls_d;
  logic [7:0]  timer_q, timer_d;
  logic        hit_q, miss_q, btn_q;
  logic        hit_p_q, miss_p_q, btn_p_q;
  logic        score_clr, score_inc;

  // Edge detectors; the detected pulse is registered so every output stays
  // a pure function of flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      btn_q    <= 1'b0;
      hit_p_q  <= 1'b0;
      miss_p_q <= 1'b0;
      btn_p_q  <= 1'b0;
    end else begin
      hit_q    <= hit;
      miss_q   <= miss;
      btn_q    <= |btn;
      hit_p_q  <= hit & ~hit_q;
      miss_p_q <= miss & ~miss_q;
      btn_p_q  <= |btn & ~btn_q;
    end
  end

  // Next-state logic for game state, ball count, delay timer and score control.
  always_comb begin
    state_d   = state_q;
    balls_d   = balls_q;
    timer_d   = timer_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    if ((state_q == ST_NEWBALL || state_q == ST_OVER) && frame_tick && timer_q != '0)
      timer_d = timer_q - 8'd1;
    case (state_q)
      ST_NEWGAME: begin
        score_clr = 1'b1;
        balls_d   = BALLS_INIT;
        if (btn_p_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (miss_p_q) begin
          timer_d = DELAY_INIT;
          if (balls_q == '0) begin
            state_d = ST_OVER;
          end else begin
            balls_d = balls_q - 2'd1;
            state_d = ST_NEWBALL;
          end
        end else if (hit_p_q) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_q == '0 && btn_p_q) state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_q == '0) begin
          state_d   = ST_NEWGAME;
          score_clr = 1'b1;
          balls_d   = BALLS_INIT;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase
  end

  // State, ball count and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_NEWGAME;
      balls_q <= BALLS_INIT;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      balls_q <= balls_d;
      timer_q <= timer_d;
    end
  end

  pong_bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .d1    (score_d1),
    .d0    (score_d0)
  );

  // Overlay message and freeze decode from the state register.
  always_comb begin
    msg_sel = MSG_NONE;
    case (state_q)
      ST_NEWGAME: msg_sel = MSG_START;
      ST_PLAY:    msg_sel = MSG_NONE;
      ST_NEWBALL: msg_sel = MSG_READY;
      ST_OVER:    msg_sel = MSG_OVER;
      default:    msg_sel = MSG_NONE;
    endcase
  end

  assign gra_still  = (state_q != ST_PLAY);
  assign balls_left = balls_q;

`ifdef PONG_HISCORE_EN
  logic       over_entry_q;
  bcd_digit_t hi_d1_q, hi_d0_q;

  // The compare runs the cycle after OVER entry, when the final score is
  // settled in the counter and no longer changes until the next game.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      over_entry_q <= 1'b0;
      hi_d1_q      <= '0;
      hi_d0_q      <= '0;
    end else begin
      over_entry_q <= (state_q == ST_PLAY) && miss_p_q && (balls_q == '0);
      if (over_entry_q && bcd_gt(score_d1, score_d0, hi_d1_q, hi_d0_q)) begin
        hi_d1_q <= score_d1;
        hi_d0_q <= score_d0;
      end
    end
  end

  assign hi_d1 = hi_d1_q;
  assign hi_d0 = hi_d0_q;
`else
  assign hi_d1 = '0;
  assign hi_d0 = '0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the stimulus process runs a game-level
// reference model and queues the expected outputs each cycle; a monitor pops
// and compares them on the falling edge.
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int DT    = 120;

  localparam int M_NEWGAME = 0;
  localparam int M_PLAY    = 1;
  localparam int M_NEWBALL = 2;
  localparam int M_OVER    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [3:0] score_d1, score_d0, hi_d1, hi_d0;
  logic [1:0] balls_left, msg_sel;

  pong_game_ctrl #(.BALLS(BALLS), .DELAY_TICKS(DT)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left),
    .msg_sel    (msg_sel),
    .hi_d1      (hi_d1),
    .hi_d0      (hi_d0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       gs;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] bl;
    logic [1:0] ms;
    logic [3:0] h1;
    logic [3:0] h0;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: game mode, score and hi-score as plain integers.
  int m_mode, m_score, m_balls, m_timer, m_hi;
  bit m_over_new;
  bit m_ph, m_pm, m_pb;
  bit m_eh, m_em, m_eb;

  function automatic int msg_of(input int mode);
    case (mode)
      M_NEWGAME: return 1;
      M_NEWBALL: return 2;
      M_OVER:    return 3;
      default:   return 0;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.gs = (m_mode != M_PLAY);
    o.d1 = 4'(m_score / 10);
    o.d0 = 4'(m_score % 10);
    o.bl = 2'(m_balls);
    o.ms = 2'(msg_of(m_mode));
    o.h1 = 4'(m_hi / 10);
    o.h0 = 4'(m_hi % 10);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {gra_still, score_d1, score_d0, balls_left, msg_sel, hi_d1, hi_d0};
    return o;
  endfunction

  task automatic model_reset();
    m_mode = M_NEWGAME; m_score = 0; m_balls = BALLS - 1; m_timer = 0; m_hi = 0;
    m_over_new = 0;
    m_ph = 0; m_pm = 0; m_pb = 0;
    m_eh = 0; m_em = 0; m_eb = 0;
  endtask

  // One clock edge of game behaviour: events seen one edge ago take effect now.
  task automatic model_step(input bit tick, input bit b, input bit h, input bit m);
    bit hp = m_eh;
    bit mp = m_em;
    bit bp = m_eb;
    int t0 = m_timer;
    m_eh = h && !m_ph; m_em = m && !m_pm; m_eb = b && !m_pb;
    m_ph = h; m_pm = m; m_pb = b;
`ifdef PONG_HISCORE_EN
    if (m_over_new && m_score > m_hi) m_hi = m_score;
`endif
    m_over_new = 0;
    if ((m_mode == M_NEWBALL || m_mode == M_OVER) && tick && t0 > 0) m_timer = t0 - 1;
    case (m_mode)
      M_NEWGAME: begin
        m_score = 0; m_balls = BALLS - 1;
        if (bp) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (mp) begin
          m_timer = DT;
          if (m_balls == 0) begin m_mode = M_OVER; m_over_new = 1; end
          else begin m_balls = m_balls - 1; m_mode = M_NEWBALL; end
        end else if (hp) begin
          m_score = (m_score + 1) % 100;
        end
      end
      M_NEWBALL: if (t0 == 0 && bp) m_mode = M_PLAY;
      default: if (t0 == 0) begin m_mode = M_NEWGAME; m_score = 0; m_balls = BALLS - 1; end
    endcase
  endtask

  // One cycle: advance the model over the coming edge, queue the expectation,
  // then drive the next input set just after the edge.
  task automatic cyc(input logic [1:0] b, input logic h, input logic m, input logic t);
    @(posedge clk);
    if (reset) model_reset();
    else model_step(frame_tick, |btn, hit, miss);
    exp_q.push_back(model_obs());
    #1;
    btn = b; hit = h; miss = m; frame_tick = t;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(2'b00, 1'b0, 1'b0, 1'b1);
      cyc(2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press();
    logic [1:0] v = 2'($urandom_range(1, 3));
    cyc(v, 1'b0, 1'b0, 1'b0);
    cyc(v, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hit_edge();
    int hi_n = $urandom_range(1, 3);
    int lo_n = $urandom_range(2, 3);
    for (int i = 0; i < hi_n; i++) cyc(2'b00, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < lo_n; i++) cyc(2'b00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic miss_edge();
    repeat (3) cyc(2'b00, 1'b0, 1'b1, 1'b0);
    repeat (2) cyc(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset landing mid-cycle: outputs must already be at reset
  // values before the next clock edge.
  task automatic async_reset_check();
    obs_t e, a;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    e = model_obs();
    a = dut_obs();
    exp_q.delete();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %h, expected %h", a, e);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_obs();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got still=%0b score=%0h%0h balls=%0d msg=%0d hi=%0h%0h, expected still=%0b score=%0h%0h balls=%0d msg=%0d hi=%0h%0h",
                   $time, a.gs, a.d1, a.d0, a.bl, a.ms, a.h1, a.h0,
                   e.gs, e.d1, e.d0, e.bl, e.ms, e.h1, e.h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rb;
    logic       rh, rm;
    model_reset();
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(3);

    // Serve, then one long hit level counts once.
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    repeat (50) cyc(2'b00, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // Climb to 95, then ten more edges wrap through 99 -> 00 to 05.
    for (int i = 0; i < 200 && m_score != 95; i++) hit_edge();
    repeat (10) hit_edge();

    // Simultaneous hit and miss: miss wins.
    repeat (3) cyc(2'b00, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(2'b00, 1'b0, 1'b0, 1'b0);

    // Early press ignored, press after expiry serves.
    ticks(50);
    press();
    ticks(75);
    press();

    repeat (2) hit_edge();
    miss_edge();
    ticks(125);
    press();
    repeat (2) hit_edge();
    miss_edge();
    ticks(125);
    idle(4);

    // Second game ends lower; high score must persist.
    press();
    repeat (3) hit_edge();
    miss_edge();
    ticks(125);
    press();
    miss_edge();
    ticks(125);
    press();
    miss_edge();
    ticks(125);
    idle(4);

    // Free-running random levels.
    rb = 2'b00; rh = 1'b0; rm = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = (rb == 2'b00) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 4) == 0) rh = ~rh;
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      cyc(rb, rh, rm, 1'($urandom_range(0, 2) == 0));
    end
    idle(2);

    // Reset out of an arbitrary state, then mid-NEWBALL with a part-run timer.
    async_reset_check();
    repeat (2) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);
    press();
    hit_edge();
    miss_edge();
    ticks(30);
    async_reset_check();
    repeat (2) cyc(2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the pong display pipeline. It drives `gra_still` into the pong graphics block and consumes that block's `hit`/`miss` flags. It also runs the per-game state machine: serve, play, ball lost, game over. It keeps a two-digit BCD score, a remaining-ball count and an inter-ball delay timer, and emits a message selector for the text overlay.

## Interface
Parameters:
- `BALLS`, 3: balls per game (1–3).
- `DELAY_TICKS`, 120: frame ticks spent in NEWBALL/OVER (2 s at 60 Hz); 8-bit counter.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per frame (start of v-sync).
- `btn`, in, 2: raw paddle buttons; any bit high = "press".
- `hit`, in, 1: level from the graphics block; high while the ball overlaps a scoring contact.
- `miss`, in, 1: level from the graphics block; high while the ball is at a losing border.
- `gra_still`, out, 1: holds ball and paddles at their home positions.
- `score_d1`, out, 4: score tens digit, BCD.
- `score_d0`, out, 4: score units digit, BCD.
- `balls_left`, out, 2: balls remaining after the current one.
- `msg_sel`, out, 2: overlay text. 0 = none, 1 = "press to start", 2 = "ready", 3 = "game over".
- `hi_d1`, out, 4: high-score tens digit, BCD.
- `hi_d0`, out, 4: high-score units digit, BCD.

## Operation
- States: NEWGAME, PLAY, NEWBALL, OVER. Reset state is NEWGAME.
- Edge detection:
  - `hit_p = hit & ~hit_q`, `miss_p = miss & ~miss_q`, `btn_p = |btn & ~btn_q`, using one flop per signal.
  - Each level is high for many cycles, so only the edge is acted on.
- NEWGAME:
  - Score is held at 00; `balls_left = BALLS-1`.
  - `btn_p` moves to PLAY.
- PLAY:
  - `hit_p` increments the score. BCD wraps 99 → 00, and d0 9 → 0 carries into d1.
  - `miss_p` with `balls_left == 0` moves to OVER.
  - `miss_p` with `balls_left > 0` decrements `balls_left` and moves to NEWBALL.
  - On either `miss_p` branch the delay timer loads `DELAY_TICKS`.
- NEWBALL:
  - The timer decrements on `frame_tick`.
  - When timer == 0 and `btn_p`, move to PLAY. Presses before expiry are ignored.
- OVER:
  - The timer decrements on `frame_tick`.
  - When timer == 0, move to NEWGAME, clearing the score and reloading `balls_left`.
- Output decode:
  - `gra_still` = 1 in every state except PLAY.
  - `msg_sel` = 1 in NEWGAME, 0 in PLAY, 2 in NEWBALL, 3 in OVER.
- Simultaneous events:
  - `hit_p` and `miss_p` in the same cycle: miss wins and the score is not incremented.
  - Timer load and `frame_tick` in the same cycle: the load wins.
- `btn` in PLAY or OVER is ignored. `hit`/`miss` outside PLAY are ignored.
- Reset mid-game (asynchronous) returns everything to reset values immediately.

## Timing
- Reset values:
  - state NEWGAME, `gra_still` = 1, score 00, `balls_left = BALLS-1`, `msg_sel` = 1.
  - Timer 0, `hi` 00, edge flops 0.
- All outputs are registered or decoded from state flops only (Moore); no combinational path from any input to any output.
- Latency:
  - Input rising edge at clock n is detected at n+1 (flop compare).
  - State, score or count update is visible at n+2.
  - `gra_still` falls two cycles after the `btn` edge.
- Timer expiry: NEWBALL exit is allowed no earlier than `DELAY_TICKS` frame ticks after entry.

## Configuration
- `PONG_HISCORE_EN` defined:
  - On the PLAY → OVER transition, if score > hi (BCD compare, d1 first), hi ← score.
  - The update is visible one cycle after OVER entry.
  - `hi` persists across games and is cleared only by reset.
- Not defined: `hi_d1`/`hi_d0` are tied to 0 and no hi-score flops exist.

## Structure
- Shared package `pong_pkg`:
  - state enum `game_state_t`.
  - `msg_sel` codes `MSG_NONE`, `MSG_START`, `MSG_READY`, `MSG_OVER`.
  - `bcd_digit_t` (4 bits).
  - `MAX_X`/`MAX_Y` constants, shared with the graphics block.
- Sub-module `pong_bcd_counter`:
  - Two-digit BCD with `clr` and `inc`, with `clr` taking priority.
  - Outputs `d1`, `d0`.
  - Instantiated once, for the score.

## Test plan
- After reset, hold `btn` = 0 → state NEWGAME, `gra_still` = 1, `msg_sel` = 1, score 00, `balls_left` = 2.
- Pulse `btn` = 01, then hold `hit` high for 50 cycles → PLAY, `gra_still` = 0, score 01 (not 50).
- In PLAY, raise 10 separate `hit` edges from score 95 → score 05 (wrap through 99 → 00).
- Raise `hit` and `miss` in the same cycle with `balls_left` = 2 → score unchanged, `balls_left` = 1, NEWBALL, `msg_sel` = 2.
  - A `btn` edge after 50 frame ticks is ignored.
  - A `btn` edge after 120 frame ticks → PLAY.
- Third miss → OVER, `msg_sel` = 3. After 120 ticks → NEWGAME with score 00.
  - With `PONG_HISCORE_EN` and score 07: hi = 07.
  - A subsequent game ending at 03 leaves hi = 07.
- Assert reset mid-NEWBALL with a partly run timer → all outputs return to reset values in the same cycle.
